matrix_product_scheduler: RTL

//  Initiator for column_processor: computes C = A x B (size x size) by issuing
//  one (row i of A, column j of B) job per output cell, collecting each cell

---
 rtl/matrix_product_scheduler.sv | 126 ++++++++++++
 1 files changed

// File: rtl/matrix_product_scheduler.sv
// Drives C = A x B through one column_processor: one (row i, col j) job at a time, row-major, j innermost.
// Latency per cell: processor latency + 4 cycles. Processor paced by its ready/ack; result held on out_ready until out_ack.
module matrix_product_scheduler #(
  parameter int size       = 4,
  parameter int cell_width = 32,
  parameter int width      = cell_width * size,
  parameter int mat_width  = width * size
) (
  input  logic                 in_clk,
  input  logic                 in_reset,
  input  logic                 in_start,
  input  logic [mat_width-1:0] in_mat_a,
  input  logic [mat_width-1:0] in_mat_b,
  input  logic                 out_ack,
  output logic [mat_width-1:0] out_mat_c,
  output logic                 out_ready,
  output logic                 out_pe_ready,
  output logic [width-1:0]     out_pe_row_a,
  output logic [width-1:0]     out_pe_col_b,
  input  logic [width-1:0]     in_pe_cell,
  input  logic                 in_pe_ready,
  output logic                 out_pe_ack
);

  localparam int idx_w = (size > 1) ? $clog2(size) : 1;
  typedef logic [idx_w-1:0] idx_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK,
    RELEASE,
    DONE
  } state_t;

  state_t               state_q;
  state_t               state_d;
  idx_t                 i_q;
  idx_t                 j_q;
  logic [mat_width-1:0] mat_a_q;
  logic [mat_width-1:0] mat_b_q;
  logic [mat_width-1:0] mat_c_q;
  logic                 last_cell;

  assign last_cell = (i_q == idx_t'(size - 1)) && (j_q == idx_t'(size - 1));

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_start) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (in_pe_ready) state_d = ACK;
      ACK:     state_d = RELEASE;
      // The processor lingers on out_ready after ack; that level is never a new result.
      RELEASE: if (!in_pe_ready) state_d = last_cell ? DONE : ISSUE;
      DONE:    if (out_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      i_q     <= '0;
      j_q     <= '0;
      mat_a_q <= '0;
      mat_b_q <= '0;
      mat_c_q <= '0;
    end else begin
      if (state_q == IDLE && in_start) begin
        mat_a_q <= in_mat_a;
        mat_b_q <= in_mat_b;
        mat_c_q <= '0;
        i_q     <= '0;
        j_q     <= '0;
      end
      if (state_q == WAIT && in_pe_ready) begin
        for (int r = 0; r < size; r++) begin
          for (int c = 0; c < size; c++) begin
            if (i_q == idx_t'(r) && j_q == idx_t'(c)) begin
              mat_c_q[(r*size+c)*cell_width +: cell_width] <= in_pe_cell[cell_width-1:0];
            end
          end
        end
      end
      if (state_q == RELEASE && !in_pe_ready && !last_cell) begin
        if (j_q == idx_t'(size - 1)) begin
          j_q <= '0;
          i_q <= i_q + 1'b1;
        end else begin
          j_q <= j_q + 1'b1;
        end
      end
    end
  end

  // i/j only move on the RELEASE->ISSUE step, so the job vectors hold from ISSUE until the next ISSUE.
  always_comb begin
    out_pe_row_a = '0;
    out_pe_col_b = '0;
    for (int r = 0; r < size; r++) begin
      for (int k = 0; k < size; k++) begin
        if (i_q == idx_t'(r)) begin
          out_pe_row_a[k*cell_width +: cell_width] = mat_a_q[(r*size+k)*cell_width +: cell_width];
        end
        if (j_q == idx_t'(r)) begin
          out_pe_col_b[k*cell_width +: cell_width] = mat_b_q[(k*size+r)*cell_width +: cell_width];
        end
      end
    end
  end

  assign out_pe_ready = (state_q == ISSUE);
  assign out_pe_ack   = (state_q == ACK);
  assign out_ready    = (state_q == DONE);
  assign out_mat_c    = mat_c_q;

endmodule
